cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's fixed 32-bit two-level CLA.
- Operand is split into STAGES equal segments; each pipeline stage adds one segment with 4-bit CLA groups plus a lookahead tier, and registers the segment carry into the next stage.
- Valid/ready handshake on both sides, add/sub mode, flag outputs.
- Sits in the datapath between operand registers and the ALU result mux.

---
 rtl/cla_pipe_adder.sv | 163 ++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one WIDTH/STAGES segment per stage, result STAGES cycles after accept.
// A single advance signal (~out_valid | out_ready) freezes every stage while the result waits.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;
  localparam int L   = STAGES - 1;

  // Returns {carry_out, sum}: 4-bit groups, then one lookahead tier across the groups.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic c0);
    logic [SEG-1:0] p, g, c;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    gc;
    logic           acc;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
        gp[j] = gp[j] & p[4*j+i];
      end
    end
    for (int j = 0; j <= NG; j++) begin
      acc = c0;
      for (int i = 0; i < j; i++) acc = gg[i] | (gp[i] & acc);
      gc[j] = acc;
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int i = 1; i < 4; i++) c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
    end
    return {gc[NG], p ^ c};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_op;
  logic             ce;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign b_op     = sub ? ~y : y;
  assign ce       = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int DONE = (k + 1) * SEG;
    localparam int REM  = WIDTH - k * SEG;
    logic [2*REM-1:0] ops;       // {x bits still to add, B bits still to add}
    logic [DONE-1:0]  sum_done;
    logic             c_seg;
    logic             v_seg;
    logic [SEG:0]     res;

    if (k == 0) begin : g_src
      assign ops      = {x, b_op};
      assign c_seg    = ce;
      assign v_seg    = in_valid & in_ready;
      assign sum_done = res[SEG-1:0];
    end else begin : g_src
      assign ops      = g_stg[k-1].g_reg.pipe_q[2*REM + k*SEG - 1 : k*SEG];
      assign c_seg    = g_stg[k-1].g_reg.carry_q;
      assign v_seg    = g_stg[k-1].g_reg.vld_q;
      assign sum_done = {res[SEG-1:0], g_stg[k-1].g_reg.pipe_q[k*SEG-1:0]};
    end

    assign res = seg_add(ops[REM +: SEG], ops[0 +: SEG], c_seg);

    if (k < STAGES - 1) begin : g_reg
      localparam int NREM = REM - SEG;
      localparam int RW   = 2 * NREM + DONE;
      logic [RW-1:0] pipe_d, pipe_q;
      logic          carry_d, carry_q;
      logic          vld_d, vld_q;

      always_comb begin
        pipe_d  = pipe_q;
        carry_d = carry_q;
        vld_d   = vld_q;
        if (advance) begin
          pipe_d  = {ops[2*REM-1 : REM+SEG], ops[REM-1 : SEG], sum_done};
          carry_d = res[SEG];
          vld_d   = v_seg;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_q  <= '0;
          carry_q <= 1'b0;
          vld_q   <= 1'b0;
        end else begin
          pipe_q  <= pipe_d;
          carry_q <= carry_d;
          vld_q   <= vld_d;
        end
      end
    end
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
  logic             msb_carry;

  // Carry into the MSB recovered from the MSB's operand and sum bits.
  assign msb_carry = g_stg[L].ops[2*SEG-1] ^ g_stg[L].ops[SEG-1] ^ g_stg[L].res[SEG-1];

  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (advance) begin
      out_valid_d = g_stg[L].v_seg;
      s_d         = g_stg[L].sum_done;
      cout_d      = g_stg[L].res[SEG];
      ovf_d       = msb_carry ^ g_stg[L].res[SEG];
      zero_d      = ~|g_stg[L].sum_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases on a 32/2 instance, then random streams on several shapes.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int go = -1;

  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] x, y, s;

  cla_pipe_adder #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] e;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, s, cout, ovf, zero} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", {out_valid, s, cout, ovf, zero});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t vt [10];
    int   lat;
    vt[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
    vt[5] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vt[6] = '{32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[8] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = vt[i].a; y = vt[i].b; cin = vt[i].ci; sub = vt[i].sb;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_in_ready got %b expected 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d expected 2", i, lat);
      end
      checks++;
      if ({s, cout, ovf, zero} !== {vt[i].e, vt[i].c, vt[i].o, vt[i].z}) begin
        errors++;
        $display("FAIL dir%0d_result got s=%h c=%b o=%b z=%b expected s=%h c=%b o=%b z=%b",
                 i, s, cout, ovf, zero, vt[i].e, vt[i].c, vt[i].o, vt[i].z);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bx [4], by [4], be [4];
    int          sent, got, stall_left;
    logic        held_v;
    logic [31:0] held_s;
    for (int i = 0; i < 4; i++) begin
      bx[i] = 32'h0FFFFFFF + 32'h10000000 * i;
      by[i] = 32'h00000001 + i;
      be[i] = bx[i] + by[i];
    end
    sent = 0; got = 0; stall_left = 3; held_v = 1'b0; held_s = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || s !== held_s) begin
          errors++;
          $display("FAIL b2b_frozen got v=%b s=%h expected v=1 s=%h", out_valid, s, held_s);
        end
      end
      out_ready = 1'b1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      in_valid = (sent < 4);
      if (sent < 4) begin x = bx[sent]; y = by[sent]; end
      cin = 1'b0; sub = 1'b0;
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready_stall got %b expected 0", in_ready);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (s !== be[got]) begin
          errors++;
          $display("FAIL b2b_result%0d got %h expected %h", got, s, be[got]);
        end
        got++;
      end
      held_v = out_valid && !out_ready;
      held_s = s;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || stall_left != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d results stall_left %0d expected 4 and 0", got, stall_left);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_no_duplicate got out_valid=%b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; x = 32'h00000001; y = 32'h00000002; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    x = 32'h00000003; y = 32'h00000004;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, s, cout, ovf, zero} !== 36'h0) begin
      errors++;
      $display("FAIL midrst_outputs got %h expected 0", {out_valid, s, cout, ovf, zero});
    end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_dropped got out_valid=%b expected 0", out_valid);
      end
    end
    in_valid = 1'b1; x = 32'hDEAD0000; y = 32'h0000BEEF;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2 || s !== 32'hDEADBEEF || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next_op got lat=%0d s=%h c=%b expected lat=2 s=deadbeef c=0", lat, s, cout);
    end
  endtask

  for (genvar c = 0; c < 5; c++) begin : g_cfg
    localparam int W = (c == 4) ? 64 : 32;
    localparam int S = (c == 0) ? 1 : (c == 1) ? 2 : (c == 2) ? 4 : (c == 3) ? 8 : 4;
    localparam logic signed [W+1:0] MAXS = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [W+1:0] MINS = $signed({3'b111, {(W-1){1'b0}}});

    logic         r_rst_n, r_in_valid, r_in_ready, r_cin, r_sub, r_out_valid, r_out_ready;
    logic         r_cout, r_ovf, r_zero;
    logic [W-1:0] r_x, r_y, r_s;

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(r_rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .x(r_x), .y(r_y), .cin(r_cin), .sub(r_sub),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .s(r_s), .cout(r_cout), .ovf(r_ovf), .zero(r_zero)
    );

    // Expected {zero, ovf, cout, s} from unsigned and signed integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
      logic [W:0]            u;
      logic signed [W+1:0]   sa, sbv, sv, sci;
      logic [W-1:0]          r;
      logic                  co, ov;
      sa  = $signed({{2{a[W-1]}}, a});
      sbv = $signed({{2{b[W-1]}}, b});
      sci = $signed({{(W+1){1'b0}}, ci});
      if (!sb) begin
        u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        co = u[W];
        sv = sa + sbv + sci;
      end else begin
        u  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
        co = ~u[W];
        sv = sa - sbv - sci;
      end
      r  = u[W-1:0];
      ov = (sv > MAXS) || (sv < MINS);
      return {(r == '0), ov, co, r};
    endfunction

    function automatic logic [W-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: r = '1;
        1: r = '0;
        default: ;
      endcase
      return r[W-1:0];
    endfunction

    task automatic test_random();
      logic [W+2:0] q [$];
      logic [W+2:0] exp_v, cur, held;
      logic         hold;
      r_rst_n = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
      repeat (2) @(negedge clk);
      r_rst_n = 1'b1;
      hold = 1'b0; held = '0;
      for (int cyc = 0; cyc < 330; cyc++) begin
        @(negedge clk);
        cur = {r_zero, r_ovf, r_cout, r_s};
        if (hold) begin
          checks++;
          if (r_out_valid !== 1'b1 || cur !== held) begin
            errors++;
            $display("FAIL rand_w%0d_s%0d_hold got %h expected %h", W, S, cur, held);
          end
        end
        r_in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
        r_out_ready = (cyc >= 300) || ($urandom_range(0, 3) != 0);
        r_x   = rnd_op();
        r_y   = ($urandom_range(0, 5) == 0) ? ~r_x : rnd_op();
        r_cin = 1'($urandom_range(0, 1));
        r_sub = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (r_in_ready !== (!r_out_valid || r_out_ready)) begin
          errors++;
          $display("FAIL rand_w%0d_s%0d_in_ready got %b expected %b", W, S, r_in_ready,
                   !r_out_valid || r_out_ready);
        end
        if (r_out_valid && r_out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rand_w%0d_s%0d_spurious got %h expected no result", W, S, cur);
          end else begin
            exp_v = q.pop_front();
            if (cur !== exp_v) begin
              errors++;
              $display("FAIL rand_w%0d_s%0d_result got %h expected %h", W, S, cur, exp_v);
            end
          end
        end
        if (r_in_valid && r_in_ready) q.push_back(model(r_x, r_y, r_cin, r_sub));
        hold = r_out_valid && !r_out_ready;
        held = cur;
      end
      r_in_valid = 1'b0;
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL rand_w%0d_s%0d_drain got %0d pending expected 0", W, S, q.size());
      end
    endtask

    initial begin
      r_rst_n = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
      r_x = '0; r_y = '0; r_cin = 1'b0; r_sub = 1'b0;
      wait (go == c);
      test_random();
      go = c + 1;
    end
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    go = 0;
    for (int n = 0; n < 5000 && go < 5; n++) @(negedge clk);
    checks++;
    if (go != 5) begin
      errors++;
      $display("FAIL random_timeout got stage %0d expected 5", go);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
